// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data requesters
// Data wins by default; a starvation counter forces fetch ahead after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_flush,
  output logic        i_resp_valid,
  output logic [31:0] i_resp_addr,
  output logic [31:0] i_resp_inst,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_wen,
  input  logic [31:0] d_req_wdata,
  input  logic [3:0]  d_req_wmask,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_rdata,
  output logic        m_req_valid,
  input  logic        m_req_ready,
  output logic [31:0] m_req_addr,
  output logic        m_req_wen,
  output logic [31:0] m_req_wdata,
  output logic [3:0]  m_req_wmask,
  input  logic        m_resp_valid,
  input  logic [31:0] m_resp_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             drop_q, drop_d;
  logic [31:0]      addr_q, addr_d;
  logic             wen_q, wen_d;
  logic             fetch_pri;
  logic             grant_i;

  always_comb begin
    fetch_pri    = (STARVE_LIMIT == 0) || (starve_cnt_q == LIMIT);
    grant_i      = i_req_valid && (!d_req_valid || fetch_pri);
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    drop_d       = drop_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    i_req_ready  = 1'b0;
    d_req_ready  = 1'b0;
    m_req_valid  = 1'b0;
    m_req_addr   = 32'h0;
    m_req_wen    = 1'b0;
    m_req_wdata  = 32'h0;
    m_req_wmask  = 4'h0;
    i_resp_valid = 1'b0;
    i_resp_addr  = addr_q;
    i_resp_inst  = m_resp_rdata;
    d_resp_valid = 1'b0;
    d_resp_rdata = 32'h0;

    case (state_q)
      IDLE: begin
        m_req_valid = i_req_valid || d_req_valid;
        if (grant_i) begin
          m_req_addr  = i_req_addr;
          i_req_ready = m_req_ready;
        end else begin
          m_req_addr  = d_req_addr;
          m_req_wen   = d_req_wen;
          m_req_wdata = d_req_wdata;
          m_req_wmask = d_req_wmask;
          d_req_ready = m_req_ready;
        end
        if (m_req_valid && m_req_ready) begin
          if (grant_i) begin
            state_d      = BUSY_I;
            addr_d       = i_req_addr;
            starve_cnt_d = '0;
          end else begin
            state_d = BUSY_D;
            wen_d   = d_req_wen;
            // Only a waiting fetch accumulates starvation; the count saturates at the limit.
            if (!i_req_valid)
              starve_cnt_d = '0;
            else if (starve_cnt_q != LIMIT)
              starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
        end
      end
      BUSY_I: begin
        i_resp_valid = m_resp_valid && !drop_q && !i_flush;
        drop_d       = drop_q || i_flush;
        if (m_resp_valid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end
      end
      BUSY_D: begin
        d_resp_valid = m_resp_valid;
        d_resp_rdata = wen_q ? 32'h0 : m_resp_rdata;
        if (m_resp_valid)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Keep every handshake and response quiet while reset is asserted.
    if (!rst_n) begin
      i_req_ready  = 1'b0;
      d_req_ready  = 1'b0;
      m_req_valid  = 1'b0;
      i_resp_valid = 1'b0;
      d_resp_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      drop_q       <= 1'b0;
      addr_q       <= 32'h0;
      wen_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      drop_q       <= drop_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_ready, i_flush, i_resp_valid;
  logic [31:0] i_req_addr, i_resp_addr, i_resp_inst;
  logic        d_req_valid, d_req_ready, d_req_wen, d_resp_valid;
  logic [31:0] d_req_addr, d_req_wdata, d_resp_rdata;
  logic [3:0]  d_req_wmask;
  logic        m_req_valid, m_req_ready, m_req_wen, m_resp_valid;
  logic [31:0] m_req_addr, m_req_wdata, m_resp_rdata;
  logic [3:0]  m_req_wmask;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_i_addr[$];
  logic [31:0] exp_i_inst[$];
  logic [31:0] exp_d[$];
  byte         glog[$];

  int          mem_dly = 2;
  int          mem_cnt = 0;
  logic        mem_hs;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_flush(i_flush), .i_resp_valid(i_resp_valid), .i_resp_addr(i_resp_addr),
    .i_resp_inst(i_resp_inst),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wen(d_req_wen), .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_wen(m_req_wen), .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
    .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h100:  return 32'h0000_0013;
      32'h200:  return 32'h00A0_0093;
      32'h400:  return 32'h0000_0073;
      32'h500:  return 32'h0010_0073;
      32'h8000: return 32'h1122_3344;
      32'h8004: return 32'h5566_7788;
      default:  return 32'hCAFE_0000;
    endcase
  endfunction

  // Response monitor and grant logger
  always @(negedge clk) begin
    if (i_resp_valid) begin
      if (exp_i_addr.size() == 0) begin
        chk("i_resp_unexpected", 32'(i_resp_valid), 32'h0);
      end else begin
        chk("i_resp_addr", i_resp_addr, exp_i_addr.pop_front());
        chk("i_resp_inst", i_resp_inst, exp_i_inst.pop_front());
      end
    end
    if (d_resp_valid) begin
      if (exp_d.size() == 0)
        chk("d_resp_unexpected", 32'(d_resp_valid), 32'h0);
      else
        chk("d_resp_rdata", d_resp_rdata, exp_d.pop_front());
    end
    if (rst_n && m_req_valid && m_req_ready)
      glog.push_back(i_req_ready ? 8'h49 : 8'h44);
  end

  // Memory model: responds mem_dly cycles after each accepted request
  initial begin
    m_resp_valid = 1'b0;
    m_resp_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_hs   = rst_n && m_req_valid && m_req_ready;
      mem_addr = m_req_addr;
      mem_wen  = m_req_wen;
      @(posedge clk);
      #2;
      m_resp_valid = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          m_resp_valid = 1'b1;
          m_resp_rdata = mem_data;
        end
      end
      if (mem_hs) begin
        mem_cnt  = mem_dly;
        mem_data = mem_wen ? 32'hFFFF_FFFF : mem_rd(mem_addr);
      end
    end
  end

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_i_addr.size() != 0 || exp_d.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk({name, "_timeout"}, 32'(n), 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_grants(input string name, input int count);
    int n = 0;
    while (glog.size() < count && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    if (n >= 80) chk({name, "_timeout"}, 32'(n), 32'h0);
  endtask

  task automatic chk_order(input string name, input string exp);
    chk({name, "_len"}, 32'(glog.size()), 32'(exp.len()));
    for (int k = 0; k < exp.len() && k < glog.size(); k++)
      chk($sformatf("%s_%0d", name, k), 32'(glog[k]), 32'(exp[k]));
  endtask

  initial begin
    rst_n = 1'b0; i_flush = 1'b0; m_req_ready = 1'b1;
    i_req_valid = 1'b1; i_req_addr = 32'h100;
    d_req_valid = 1'b1; d_req_addr = 32'h8000; d_req_wen = 1'b0;
    d_req_wdata = 32'h0; d_req_wmask = 4'h0;
    @(negedge clk);
    chk("rst_m_req_valid", 32'(m_req_valid), 32'h0);
    chk("rst_i_req_ready", 32'(i_req_ready), 32'h0);
    chk("rst_d_req_ready", 32'(d_req_ready), 32'h0);
    chk("rst_i_resp_valid", 32'(i_resp_valid), 32'h0);
    chk("rst_d_resp_valid", 32'(d_resp_valid), 32'h0);
    @(posedge clk); #1;
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: fetch only
    exp_i_addr.push_back(32'h100); exp_i_inst.push_back(32'h0000_0013);
    i_req_valid = 1'b1; i_req_addr = 32'h100;
    @(negedge clk);
    chk("t1_i_req_ready", 32'(i_req_ready), 32'h1);
    chk("t1_m_req_addr", m_req_addr, 32'h100);
    chk("t1_m_req_wen", 32'(m_req_wen), 32'h0);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    wait_done("t1");

    // 2: simultaneous, data first then fetch
    glog.delete();
    exp_d.push_back(32'h1122_3344);
    exp_i_addr.push_back(32'h200); exp_i_inst.push_back(32'h00A0_0093);
    i_req_valid = 1'b1; i_req_addr = 32'h200;
    d_req_valid = 1'b1; d_req_addr = 32'h8000; d_req_wen = 1'b0;
    @(negedge clk);
    chk("t2_d_req_ready", 32'(d_req_ready), 32'h1);
    chk("t2_i_req_ready", 32'(i_req_ready), 32'h0);
    chk("t2_m_req_addr", m_req_addr, 32'h8000);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    run_grants("t2", 2);
    wait_done("t2");
    chk_order("t2_order", "DI");

    // 3: starvation limit forces fetch after four data grants
    glog.delete();
    for (int k = 0; k < 5; k++) exp_d.push_back(32'h5566_7788);
    exp_i_addr.push_back(32'h500); exp_i_inst.push_back(32'h0010_0073);
    i_req_valid = 1'b1; i_req_addr = 32'h500;
    d_req_valid = 1'b1; d_req_addr = 32'h8004;
    run_grants("t3", 6);
    wait_done("t3");
    chk_order("t3_order", "DDDDID");

    // 4: flush drops in-flight fetch; flush in IDLE does not affect a new fetch
    i_req_valid = 1'b1; i_req_addr = 32'h300;
    @(posedge clk); #1;
    i_req_valid = 1'b0; i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    exp_i_addr.push_back(32'h400); exp_i_inst.push_back(32'h0000_0073);
    i_req_valid = 1'b1; i_req_addr = 32'h400; i_flush = 1'b1;
    @(posedge clk); #1;
    i_req_valid = 1'b0; i_flush = 1'b0;
    wait_done("t4");

    // 5: store
    exp_d.push_back(32'h0);
    d_req_valid = 1'b1; d_req_wen = 1'b1; d_req_addr = 32'h9000;
    d_req_wdata = 32'hDEAD_BEEF; d_req_wmask = 4'hF;
    @(negedge clk);
    chk("t5_m_req_addr", m_req_addr, 32'h9000);
    chk("t5_m_req_wen", 32'(m_req_wen), 32'h1);
    chk("t5_m_req_wdata", m_req_wdata, 32'hDEAD_BEEF);
    chk("t5_m_req_wmask", 32'(m_req_wmask), 32'hF);
    @(posedge clk); #1;
    d_req_valid = 1'b0; d_req_wen = 1'b0;
    wait_done("t5");

    // 6: backpressure, then reset in BUSY_D with a late response
    m_req_ready = 1'b0; mem_dly = 4;
    d_req_valid = 1'b1; d_req_addr = 32'h8008;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t6_bp_valid_%0d", k), 32'(m_req_valid), 32'h1);
      chk($sformatf("t6_bp_addr_%0d", k), m_req_addr, 32'h8008);
      chk($sformatf("t6_bp_ready_%0d", k), 32'(d_req_ready), 32'h0);
    end
    @(posedge clk); #1;
    m_req_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_busy_m_valid", 32'(m_req_valid), 32'h0);
    chk("t6_busy_d_ready", 32'(d_req_ready), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_m_valid", 32'(m_req_valid), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; d_req_valid = 1'b0; m_req_ready = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 32'h600;
    @(negedge clk);
    chk("t6_idle_m_valid", 32'(m_req_valid), 32'h1);
    chk("t6_idle_m_addr", m_req_addr, 32'h600);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    chk("end_exp_i_empty", 32'(exp_i_addr.size()), 32'h0);
    chk("end_exp_d_empty", 32'(exp_d.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
